uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit path stage between the TX byte FIFO and the `tx` pin of the UART peripheral.
- Pops bytes from a show-ahead FIFO and applies CTS flow control.
- Generates bit timing from a programmable clocks-per-bit divisor.
- Serialises 8N1 frames (start bit, 8 data bits LSB first, stop bit) and reports busy/done to the bus-facing wrapper.

Parameters:
- DataBits, 8, payload bits per frame.
- RateWidth, 16, width of the clocks-per-bit divisor.

Ports:
- clk  input  1  system clock.
- nReset  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- rate  input  RateWidth  clocks per bit; sampled at frame start.
- flow_en  input  1  1 = obey cts; 0 = ignore cts.
- cts  input  1  remote ready-to-receive; active high.
- clear  input  1  abort current frame, return to idle.
- fifo_rdata  input  DataBits  head of TX FIFO; valid when !fifo_empty.
- fifo_empty  input  1  TX FIFO empty.
- fifo_ren  output  1  pop strobe to TX FIFO; combinational, one cycle per frame.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (nReset=0 at posedge): state IDLE, tx=1, busy=0, done=0, counters 0. fifo_ren=0 while in reset.
- States: IDLE, START, DATA, STOP.
- Start condition, evaluated in IDLE: !fifo_empty && (cts || !flow_en) && !clear.
- IDLE with start condition:
  - fifo_ren=1 in the same cycle.
  - fifo_rdata captured into shift register.
  - rate latched as eff_rate = (rate==0) ? 1 : rate.
  - bit counter cleared; next state START.
- IDLE otherwise: fifo_ren=0, tx=1, busy=0.
- tx, busy and done are registered. tx=0 and busy=1 from the cycle after the pop.
- Each bit lasts exactly eff_rate cycles. Bit timer counts 0..eff_rate-1; a "bit_end" tick fires at eff_rate-1.
- START: tx=0; on bit_end go to DATA with tx=shift[0].
- DATA:
  - tx=shift[0]; on bit_end shift right, increment bit index.
  - After DataBits bits go to STOP (tx=1).
- STOP: tx=1; on bit_end go to IDLE, busy=0, done=1 for that single cycle.
- Frame duration: (DataBits+2)*eff_rate cycles, first tx low to IDLE entry.
- Minimum gap between frames: 1 idle cycle, because the next pop occurs in IDLE.
- cts is sampled only at the start condition. cts falling mid-frame does not stop the frame; the frame completes normally.
- rate changes mid-frame are ignored until the next frame.
- clear has priority over everything except reset:
  - Next cycle: state IDLE, tx=1, busy=0, done=0.
  - fifo_ren=0 in any cycle where clear=1.
  - An aborted byte is lost; no done pulse.
- fifo_empty rising mid-frame has no effect on the current frame.
- Reset mid-frame: same as the reset values above; no done pulse.
- fifo_ren is never asserted while busy=1 or while fifo_empty=1, so it cannot underrun the FIFO.

Decomposition:
- Shared package uart_pkg holds:
  - enum uart_tx_state_t {IDLE, START, DATA, STOP};
  - constant UART_DATA_BITS=8;
  - constant UART_RATE_WIDTH=16.
- Sub-module uart_bit_timer (RateWidth counter):
  - Inputs: clk, nReset, restart, eff_rate.
  - Output: bit_end pulse.
  - Reused later by the receive-side sampler.

Test Plan:
- Basic frame: rate=4, flow_en=0, FIFO holds 0xA5.
  - fifo_ren pulses 1 cycle.
  - From the next cycle tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - done pulses once, 40 cycles after tx first falls; busy high exactly 40 cycles.
- Flow control: flow_en=1, cts=0, FIFO holds 0x3C.
  - No fifo_ren and tx=1 for 100 cycles.
  - Raise cts: fifo_ren in that cycle, tx falls the next cycle.
  - Drop cts at data bit 3: frame still completes with done.
- Back-to-back: rate=2, FIFO holds 0x00 then 0xFF.
  - Two fifo_ren pulses 21 cycles apart; one idle-high cycle between frames.
  - Second frame's data bits all 1.
- Clear mid-frame: rate=8, byte 0x55, assert clear for 1 cycle in DATA bit 2.
  - Next cycle tx=1, busy=0, no done.
  - Next FIFO byte starts a clean frame afterwards.
- Rate edge case: rate=0, byte 0x81.
  - Each bit lasts 1 cycle; frame = 10 cycles.
  - Change rate to 5 mid-frame: no effect until the next frame.
- Reset mid-frame: deassert nReset during STOP.
  - Next cycle tx=1, busy=0, done=0, fifo_ren=0 while nReset=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, divisor width and transmit FSM states.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_RATE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Show-ahead TX FIFO read port: head byte, empty flag and the pop strobe.
// The serializer consumes bytes through the master modport; the FIFO sits on the slave side.
interface uart_tx_serializer_if #(
  parameter int DataBits = uart_pkg::UART_DATA_BITS
);

  logic [DataBits-1:0] fifo_rdata;
  logic                fifo_empty;
  logic                fifo_ren;

  modport master (
    input  fifo_rdata,
    input  fifo_empty,
    output fifo_ren
  );

  modport slave (
    output fifo_rdata,
    output fifo_empty,
    input  fifo_ren
  );

endinterface

// File: rtl/uart_tx_serializer_bit_timer.sv
// Bit period timer: counts 0..eff_rate-1 and flags the last cycle of each bit.
// Shared with the receive-side sampler, so it knows nothing about frame structure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int RateWidth = UART_RATE_WIDTH
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 restart,
  input  logic [RateWidth-1:0] eff_rate,
  output logic                 bit_end
);

  localparam logic [RateWidth-1:0] RateOne = RateWidth'(1);

  logic [RateWidth-1:0] count;

  assign bit_end = (count == (eff_rate - RateOne));

  // Count within a bit period, wrapping on bit_end and holding at zero while restart is high.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      count <= '0;
    end else if (restart || bit_end) begin
      count <= '0;
    end else begin
      count <= count + RateOne;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 transmit serializer: pops a byte from the TX FIFO when the line is free and the
// remote side is ready, then shifts out start bit, data LSB first and stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DataBits  = UART_DATA_BITS,
  parameter int RateWidth = UART_RATE_WIDTH
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic [RateWidth-1:0] rate,
  input  logic                 flow_en,
  input  logic                 cts,
  input  logic                 clear,
  uart_tx_serializer_if.master fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int                   IdxWidth = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam logic [IdxWidth-1:0]  IdxOne   = IdxWidth'(1);
  localparam logic [IdxWidth-1:0]  IdxLast  = IdxWidth'(DataBits - 1);
  localparam logic [RateWidth-1:0] RateOne  = RateWidth'(1);

  uart_tx_state_t        state;
  uart_tx_state_t        stateNext;
  logic                  txNext;
  logic                  busyNext;
  logic                  doneNext;
  logic                  popNow;
  logic                  shiftNow;
  logic                  bitEnd;
  logic [DataBits-1:0]   shiftReg;
  logic [IdxWidth-1:0]   bitIdx;
  logic [RateWidth-1:0]  effRate;

  assign fifo.fifo_ren = popNow;

  // The timer idles at zero between frames so START always begins a full bit period.
  uart_bit_timer #(
    .RateWidth(RateWidth)
  ) bitTimer (
    .clk     (clk),
    .nReset  (nReset),
    .restart ((state == IDLE) || clear),
    .eff_rate(effRate),
    .bit_end (bitEnd)
  );

  // Next state and next registered line levels; clear overrides every frame transition.
  always_comb begin
    stateNext = state;
    txNext    = tx;
    busyNext  = busy;
    doneNext  = 1'b0;
    popNow    = 1'b0;
    shiftNow  = 1'b0;
    if (clear) begin
      stateNext = IDLE;
      txNext    = 1'b1;
      busyNext  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txNext   = 1'b1;
          busyNext = 1'b0;
          if (nReset && !fifo.fifo_empty && (cts || !flow_en)) begin
            popNow    = 1'b1;
            stateNext = START;
            txNext    = 1'b0;
            busyNext  = 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            stateNext = DATA;
            txNext    = shiftReg[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            shiftNow = 1'b1;
            if (bitIdx == IdxLast) begin
              stateNext = STOP;
              txNext    = 1'b1;
            end else begin
              txNext = shiftReg[1];
            end
          end
        end
        STOP: begin
          txNext = 1'b1;
          if (bitEnd) begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end
        end
        default: begin
          stateNext = IDLE;
          txNext    = 1'b1;
          busyNext  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and the registered line/status outputs.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      tx    <= txNext;
      busy  <= busyNext;
      done  <= doneNext;
    end
  end

  // Frame datapath: capture byte and divisor at the pop, then shift one bit per period.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      shiftReg <= '0;
      bitIdx   <= '0;
      effRate  <= '0;
    end else if (popNow) begin
      shiftReg <= fifo.fifo_rdata;
      bitIdx   <= '0;
      effRate  <= (rate == '0) ? RateOne : rate;
    end else if (shiftNow) begin
      shiftReg <= shiftReg >> 1;
      bitIdx   <= bitIdx + IdxOne;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: directed scenarios followed by random traffic, compared every
// cycle against a frame-level model (start time, divisor, and the ten line levels).
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        nReset;
  logic [15:0] rate;
  logic        flow_en;
  logic        cts;
  logic        clear;
  logic        tx;
  logic        busy;
  logic        done;

  uart_tx_serializer_if fifoIf ();

  uart_tx_serializer dut (
    .clk    (clk),
    .nReset (nReset),
    .rate   (rate),
    .flow_en(flow_en),
    .cts    (cts),
    .clear  (clear),
    .fifo   (fifoIf),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  logic [7:0] fifoQ[$];
  int         cyc;
  int         compared;
  int         mismatched;
  bit         checkEn;
  bit         frameValid;
  int         mStart;
  int         mRate;
  int         doneAt;
  int         lvl[10];

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  // Present the queue head on the show-ahead FIFO port.
  task automatic updateFifo();
    fifoIf.fifo_empty = (fifoQ.size() == 0);
    fifoIf.fifo_rdata = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
  endtask

  // One clock: check outputs against the model, advance the model, apply the FIFO pop.
  task automatic applyStimulus();
    logic       inFrame;
    logic       expRen;
    logic       sampledRen;
    logic [7:0] b;
    int         expTx;
    #1;
    inFrame = frameValid && (cyc >= mStart) && (cyc < doneAt);
    expRen  = nReset && !clear && !inFrame && (fifoQ.size() > 0) && (cts || !flow_en);
    expTx   = inFrame ? lvl[(cyc - mStart) / mRate] : 1;
    sampledRen = fifoIf.fifo_ren;
    if (checkEn) begin
      checkOutput("fifo_ren", 32'(fifoIf.fifo_ren), 32'(expRen));
      checkOutput("tx", 32'(tx), 32'(expTx));
      checkOutput("busy", 32'(busy), 32'(inFrame));
      checkOutput("done", 32'(done), 32'(frameValid && (cyc == doneAt)));
    end
    if (!nReset || clear) begin
      frameValid = 1'b0;
    end else if (expRen) begin
      b          = fifoQ[0];
      frameValid = 1'b1;
      mStart     = cyc + 1;
      mRate      = (rate == 16'd0) ? 1 : int'(rate);
      doneAt     = mStart + 10 * mRate;
      lvl[0]     = 0;
      for (int i = 0; i < 8; i++) lvl[i + 1] = int'(b[i]);
      lvl[9]     = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!nReset) checkEn = 1'b1;
    if (sampledRen && (fifoQ.size() > 0)) void'(fifoQ.pop_front());
    updateFifo();
    @(negedge clk);
  endtask

  initial begin
    nReset     = 1'b0;
    rate       = 16'd4;
    flow_en    = 1'b0;
    cts        = 1'b0;
    clear      = 1'b0;
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    checkEn    = 1'b0;
    frameValid = 1'b0;
    mStart     = 0;
    mRate      = 1;
    doneAt     = 0;
    updateFifo();
    @(negedge clk);
    repeat (2) applyStimulus();
    nReset = 1'b1;
    repeat (3) applyStimulus();

    $display("[TB] basic frame 0xA5 at rate 4");
    fifoQ.push_back(8'hA5);
    updateFifo();
    repeat (45) applyStimulus();

    $display("[TB] flow control hold then release");
    flow_en = 1'b1;
    cts     = 1'b0;
    fifoQ.push_back(8'h3C);
    updateFifo();
    repeat (100) applyStimulus();
    cts = 1'b1;
    applyStimulus();
    while (cyc < mStart + 16) applyStimulus();
    cts = 1'b0;
    repeat (40) applyStimulus();

    $display("[TB] back-to-back 0x00, 0xFF at rate 2");
    flow_en = 1'b0;
    rate    = 16'd2;
    fifoQ.push_back(8'h00);
    fifoQ.push_back(8'hFF);
    updateFifo();
    repeat (50) applyStimulus();

    $display("[TB] clear during data bit 2");
    rate = 16'd8;
    fifoQ.push_back(8'h55);
    updateFifo();
    applyStimulus();
    while (cyc < mStart + 26) applyStimulus();
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    repeat (5) applyStimulus();
    fifoQ.push_back(8'h96);
    updateFifo();
    repeat (90) applyStimulus();

    $display("[TB] rate 0 then mid-frame rate change");
    rate = 16'd0;
    fifoQ.push_back(8'h81);
    fifoQ.push_back(8'h42);
    updateFifo();
    repeat (4) applyStimulus();
    rate = 16'd5;
    repeat (70) applyStimulus();

    $display("[TB] reset during stop bit");
    rate = 16'd3;
    fifoQ.push_back(8'hC3);
    updateFifo();
    applyStimulus();
    while (cyc < mStart + 28) applyStimulus();
    nReset = 1'b0;
    fifoQ.push_back(8'h5A);
    updateFifo();
    repeat (2) applyStimulus();
    nReset = 1'b1;
    repeat (40) applyStimulus();

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      if (($urandom_range(0, 9) == 0) && (fifoQ.size() < 4)) begin
        fifoQ.push_back(8'($urandom_range(0, 255)));
        updateFifo();
      end
      if ($urandom_range(0, 19) == 0) rate = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) flow_en = ~flow_en;
      if ($urandom_range(0, 7) == 0) cts = 1'($urandom_range(0, 1));
      clear  = ($urandom_range(0, 149) == 0);
      nReset = !($urandom_range(0, 399) == 0);
      applyStimulus();
    end
    clear  = 1'b0;
    nReset = 1'b1;
    repeat (10) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
